// File: rtl/scramble_rand_server.sv
// Burst random-value responder: a request edge yields MOVES values in [0,RAND_MAX], then a done pulse.
// Latency: first rand_valid two cycles after the request edge; no backpressure, mix_state=0 aborts.
module scramble_rand_server #(
  parameter int          RAND_MAX = 31,
  parameter int          MOVES    = 8,
  parameter logic [15:0] SEED     = 16'hACE1,
  localparam int         OUT_W    = (RAND_MAX > 0) ? $clog2(RAND_MAX + 1) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rand_req,
  input  logic             mix_state,
  output logic [OUT_W-1:0] rand_value,
  output logic             rand_valid,
  output logic             busy,
  output logic             scramble_done
);

  localparam int               CNT_W = $clog2(MOVES + 1);
  localparam logic [15:0]      MASK  = 16'hB400;
  localparam logic [OUT_W-1:0] MAX_V = OUT_W'(RAND_MAX);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(MOVES - 1);

  typedef enum logic [1:0] {IDLE, DRAW, GAP, DONE} state_t;

  state_t           state, state_nxt;
  logic [15:0]      lfsr, lfsr_nxt;
  logic             req_d, start, accept;
  logic [CNT_W-1:0] count, count_nxt;
  logic [OUT_W-1:0] cand, value_nxt;
  logic             valid_nxt, busy_nxt, done_nxt;

  // Free-running Galois LFSR; the zero reload only matters if SEED is misconfigured.
  always_comb begin
    lfsr_nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? MASK : 16'h0000);
    if (lfsr == 16'h0000) lfsr_nxt = SEED;
  end

  assign start  = rand_req & ~req_d;
  assign cand   = lfsr[OUT_W-1:0];
  assign accept = (cand <= MAX_V) &&
                  ((count == '0) || (RAND_MAX == 0) || (cand != rand_value));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      lfsr          <= SEED;
      req_d         <= 1'b0;
      count         <= '0;
      rand_value    <= '0;
      rand_valid    <= 1'b0;
      busy          <= 1'b0;
      scramble_done <= 1'b0;
    end else begin
      state         <= state_nxt;
      lfsr          <= lfsr_nxt;
      req_d         <= rand_req;
      count         <= count_nxt;
      rand_value    <= value_nxt;
      rand_valid    <= valid_nxt;
      busy          <= busy_nxt;
      scramble_done <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start && mix_state) state_nxt = DRAW;
      DRAW: begin
        if (!mix_state)  state_nxt = IDLE;
        else if (accept) state_nxt = (count == LAST) ? DONE : GAP;
      end
      GAP:     state_nxt = mix_state ? DRAW : IDLE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs; rand_value holds unless a draw is accepted.
  always_comb begin
    value_nxt = rand_value;
    count_nxt = count;
    valid_nxt = 1'b0;
    done_nxt  = 1'b0;
    busy_nxt  = busy;
    case (state)
      IDLE: begin
        busy_nxt = start && mix_state;
        if (start && mix_state) count_nxt = '0;
      end
      DRAW: begin
        if (!mix_state) begin
          busy_nxt = 1'b0;
        end else if (accept) begin
          value_nxt = cand;
          valid_nxt = 1'b1;
          count_nxt = count + 1'b1;
        end
      end
      GAP:  if (!mix_state) busy_nxt = 1'b0;
      DONE: begin
        busy_nxt = 1'b0;
        done_nxt = mix_state;
      end
      default: busy_nxt = 1'b0;
    endcase
  end

endmodule
